// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges memory-wait, multi-cycle execute, jump and load-use
// hazards into hold_flag/hold_time. Optional memory watchdog enabled by PIPE_HOLD_TIMEOUT_EN.
//
// state   | meaning
// RUN     | normal issue; evaluates hazard requests by priority
// MEMWAIT | load/store outstanding, whole pipe held until the bus acks
// MULTI   | multi-cycle execute in progress, cnt holds remaining cycles
module pipe_hold_ctrl #(
   parameter int unsigned MULTI_CYCLES   = 8,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req_i,
   input  logic        mem_ack_i,
   input  logic        multi_start_i,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        load_use_i,
   output logic [2:0]  hold_flag_o,
   output logic [2:0]  hold_time_o,
   output logic        jump_flag_o,
   output logic [31:0] jump_addr_o,
   output logic        flush_o,
   output logic [31:0] stall_cnt_o,
   output logic        bus_err_o
);

   localparam logic [2:0] HOLD_NONE = 3'b000;
   localparam logic [2:0] HOLD_IF   = 3'b010;
   localparam logic [2:0] HOLD_ID   = 3'b011;
   localparam logic [2:0] HOLD_EX   = 3'b100;

   localparam logic [7:0] CNT_LOAD = 8'(MULTI_CYCLES - 1);

   if (MULTI_CYCLES < 2 || MULTI_CYCLES > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
   begin : g_param_check
      $error("pipe_hold_ctrl: MULTI_CYCLES or TIMEOUT_CYCLES out of range");
   end

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      MULTI   = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [2:0]  hold_flag, hold_time;
   logic        jump_flag, flush, bus_err;
   logic [31:0] jump_addr;

`ifdef PIPE_HOLD_TIMEOUT_EN
   localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT_CYCLES);
   logic [7:0] wait_cnt, wait_nxt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef PIPE_HOLD_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wait_cnt <= 8'd0;
      else     wait_cnt <= wait_nxt;
   end
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hold_flag = HOLD_NONE;
      hold_time = 3'd0;
      jump_flag = 1'b0;
      jump_addr = 32'd0;
      flush     = 1'b0;
      bus_err   = 1'b0;
`ifdef PIPE_HOLD_TIMEOUT_EN
      wait_nxt  = wait_cnt;
`endif
      case (state)
         RUN: begin
            if (mem_req_i && !mem_ack_i) begin
               hold_flag = HOLD_EX;
               hold_time = 3'd7;
               state_nxt = MEMWAIT;
`ifdef PIPE_HOLD_TIMEOUT_EN
               wait_nxt  = 8'd0;
`endif
            end else if (multi_start_i) begin
               hold_flag = HOLD_ID;
               cnt_nxt   = CNT_LOAD;
               state_nxt = MULTI;
            end else if (jump_flag_i) begin
               jump_flag = 1'b1;
               jump_addr = jump_addr_i;
               flush     = 1'b1;
            end else if (load_use_i) begin
               hold_flag = HOLD_IF;
            end
         end
         MEMWAIT: begin
            if (mem_ack_i) begin
               state_nxt = RUN;
`ifdef PIPE_HOLD_TIMEOUT_EN
            end else if (wait_cnt == WAIT_LIM) begin
               bus_err   = 1'b1;
               state_nxt = RUN;
            end else begin
               hold_flag = HOLD_EX;
               hold_time = 3'd7;
               wait_nxt  = wait_cnt + 8'd1;
            end
`else
            end else begin
               hold_flag = HOLD_EX;
               hold_time = 3'd7;
            end
`endif
         end
         MULTI: begin
            if (cnt != 8'd0) begin
               hold_flag = HOLD_ID;
               hold_time = (cnt > 8'd7) ? 3'd7 : cnt[2:0];
               cnt_nxt   = cnt - 8'd1;
            end else begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // Outputs are forced quiet while reset is held so consumers never see a stale hold.
   assign hold_flag_o = rst ? HOLD_NONE : hold_flag;
   assign hold_time_o = rst ? 3'd0      : hold_time;
   assign jump_flag_o = rst ? 1'b0      : jump_flag;
   assign jump_addr_o = rst ? 32'd0     : jump_addr;
   assign flush_o     = rst ? 1'b0      : flush;
   assign bus_err_o   = rst ? 1'b0      : bus_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          stall_cnt_o <= 32'd0;
      else if (hold_flag_o != HOLD_NONE) stall_cnt_o <= stall_cnt_o + 32'd1;
   end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed self-checking bench for pipe_hold_ctrl; timeout scenario runs when
// PIPE_HOLD_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4 here).
module tb_pipe_hold_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_ack, multi_start, jump_flag, load_use;
   logic [31:0] jump_addr;
   logic [2:0]  hold_flag, hold_time;
   logic        jump_flag_out, flush, bus_err;
   logic [31:0] jump_addr_out, stall_cnt;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_stall = 32'd0;

   pipe_hold_ctrl #(.MULTI_CYCLES(8), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .mem_req_i(mem_req), .mem_ack_i(mem_ack), .multi_start_i(multi_start),
      .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .load_use_i(load_use),
      .hold_flag_o(hold_flag), .hold_time_o(hold_time),
      .jump_flag_o(jump_flag_out), .jump_addr_o(jump_addr_out),
      .flush_o(flush), .stall_cnt_o(stall_cnt), .bus_err_o(bus_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_req = 0; mem_ack = 0; multi_start = 0;
      jump_flag = 0; jump_addr = 32'd0; load_use = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      tick(); tick();
      n_checks++;
      if ({hold_flag, hold_time, jump_flag_out, flush, bus_err, jump_addr_out, stall_cnt} !== 73'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got flag=%b time=%b stall=%0d, want all zero", hold_flag, hold_time, stall_cnt);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++;
         if ({hold_flag, hold_time, jump_flag_out, flush, bus_err, jump_addr_out, stall_cnt} !== 73'd0) begin
            n_errors++;
            $display("FAIL idle_c%0d: got flag=%b time=%b stall=%0d, want all zero", i, hold_flag, hold_time, stall_cnt);
         end
         tick();
      end
   endtask

   task automatic test_mem_wait();
      mem_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_ack = (i == 3);
         #1;
         n_checks++;
         if (i < 3) begin
            if (hold_flag !== 3'b100 || hold_time !== 3'b111 || bus_err !== 1'b0) begin
               n_errors++;
               $display("FAIL mem_hold_c%0d: got flag=%b time=%b err=%b, want 100 111 0", i, hold_flag, hold_time, bus_err);
            end
            exp_stall++;
         end else if (hold_flag !== 3'b000 || hold_time !== 3'b000) begin
            n_errors++;
            $display("FAIL mem_ack_release: got flag=%b time=%b, want 000 000", hold_flag, hold_time);
         end
         tick();
      end
      mem_req = 1'b1; mem_ack = 1'b1;
      #1;
      n_checks++;
      if (hold_flag !== 3'b000) begin
         n_errors++;
         $display("FAIL mem_req_ack_same: got flag=%b, want 000", hold_flag);
      end
      tick();
      clear_inputs();
      #1;
      n_checks++;
      if (stall_cnt !== exp_stall) begin
         n_errors++;
         $display("FAIL mem_stall_cnt: got %0d, want %0d", stall_cnt, exp_stall);
      end
   endtask

   task automatic test_multi();
      logic [2:0] exp_time;
      for (int i = 0; i < 9; i++) begin
         multi_start = (i == 0);
         jump_flag   = (i == 3);
         jump_addr   = (i == 3) ? 32'hDEAD_BEE0 : 32'd0;
         load_use    = (i == 5);
         exp_time    = (i == 0 || i == 8) ? 3'd0 : 3'(8 - i);
         #1;
         n_checks++;
         if (i < 8) begin
            if (hold_flag !== 3'b011 || hold_time !== exp_time || jump_flag_out !== 1'b0 || flush !== 1'b0
                || jump_addr_out !== 32'd0) begin
               n_errors++;
               $display("FAIL multi_c%0d: got flag=%b time=%b jmp=%b flush=%b, want 011 %b 0 0",
                        i, hold_flag, hold_time, jump_flag_out, flush, exp_time);
            end
            exp_stall++;
         end else if (hold_flag !== 3'b000 || hold_time !== 3'b000) begin
            n_errors++;
            $display("FAIL multi_release: got flag=%b time=%b, want 000 000", hold_flag, hold_time);
         end
         tick();
      end
      clear_inputs();
      #1;
      n_checks++;
      if (stall_cnt !== exp_stall || hold_flag !== 3'b000) begin
         n_errors++;
         $display("FAIL multi_stall_cnt: got %0d flag=%b, want %0d 000", stall_cnt, hold_flag, exp_stall);
      end
   endtask

   task automatic test_jump_load_use();
      jump_flag = 1'b1; jump_addr = 32'h0000_0100; load_use = 1'b1;
      #1;
      n_checks++;
      if (jump_flag_out !== 1'b1 || jump_addr_out !== 32'h100 || flush !== 1'b1 || hold_flag !== 3'b000) begin
         n_errors++;
         $display("FAIL jump_redirect: got jmp=%b addr=%h flush=%b flag=%b, want 1 00000100 1 000",
                  jump_flag_out, jump_addr_out, flush, hold_flag);
      end
      tick();
      jump_flag = 1'b0; jump_addr = 32'h0000_0200;
      #1;
      n_checks++;
      if (hold_flag !== 3'b010 || hold_time !== 3'b000 || jump_addr_out !== 32'd0 || flush !== 1'b0) begin
         n_errors++;
         $display("FAIL load_use_hold: got flag=%b time=%b addr=%h flush=%b, want 010 000 0 0",
                  hold_flag, hold_time, jump_addr_out, flush);
      end
      exp_stall++;
      tick();
      clear_inputs();
      #1;
      n_checks++;
      if (hold_flag !== 3'b000 || stall_cnt !== exp_stall) begin
         n_errors++;
         $display("FAIL load_use_release: got flag=%b stall=%0d, want 000 %0d", hold_flag, stall_cnt, exp_stall);
      end
   endtask

   task automatic test_priority();
      mem_req = 1'b1; multi_start = 1'b1; jump_flag = 1'b1; jump_addr = 32'h40;
      #1;
      n_checks++;
      if (hold_flag !== 3'b100 || jump_flag_out !== 1'b0 || flush !== 1'b0) begin
         n_errors++;
         $display("FAIL prio_mem_first: got flag=%b jmp=%b flush=%b, want 100 0 0", hold_flag, jump_flag_out, flush);
      end
      exp_stall++;
      tick();
      mem_ack = 1'b1;
      tick();
      clear_inputs();
      #1;
      n_checks++;
      if (hold_flag !== 3'b000 || stall_cnt !== exp_stall) begin
         n_errors++;
         $display("FAIL prio_multi_dropped: got flag=%b stall=%0d, want 000 %0d", hold_flag, stall_cnt, exp_stall);
      end
   endtask

   task automatic test_rst_mid_wait();
      mem_req = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (hold_flag !== 3'b000 || hold_time !== 3'b000 || stall_cnt !== 32'd0) begin
         n_errors++;
         $display("FAIL rst_mid_wait: got flag=%b time=%b stall=%0d, want 000 000 0", hold_flag, hold_time, stall_cnt);
      end
      tick();
      clear_inputs();
      rst = 1'b0;
      exp_stall = 32'd0;
      #1;
      n_checks++;
      if (hold_flag !== 3'b000 || stall_cnt !== 32'd0) begin
         n_errors++;
         $display("FAIL rst_back_in_run: got flag=%b stall=%0d, want 000 0", hold_flag, stall_cnt);
      end
      tick();
      n_checks++;
      if (hold_flag !== 3'b000 || stall_cnt !== 32'd0) begin
         n_errors++;
         $display("FAIL rst_after_edge: got flag=%b stall=%0d, want 000 0", hold_flag, stall_cnt);
      end
   endtask

`ifdef PIPE_HOLD_TIMEOUT_EN
   task automatic test_timeout();
      int err_seen = 0;
      mem_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_checks++;
         if (i < 5) begin
            if (hold_flag !== 3'b100 || bus_err !== 1'b0) begin
               n_errors++;
               $display("FAIL timeout_hold_c%0d: got flag=%b err=%b, want 100 0", i, hold_flag, bus_err);
            end
            exp_stall++;
         end else if (hold_flag !== 3'b000 || bus_err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_err: got flag=%b err=%b, want 000 1", hold_flag, bus_err);
         end
         if (bus_err === 1'b1) err_seen++;
         tick();
      end
      mem_req = 1'b0;
      #1;
      n_checks++;
      if (hold_flag !== 3'b000 || bus_err !== 1'b0 || err_seen != 1 || stall_cnt !== exp_stall) begin
         n_errors++;
         $display("FAIL timeout_return: got flag=%b err=%b pulses=%0d stall=%0d, want 000 0 1 %0d",
                  hold_flag, bus_err, err_seen, stall_cnt, exp_stall);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_mem_wait();
      test_multi();
      test_jump_load_use();
      test_priority();
      test_rst_mid_wait();
`ifdef PIPE_HOLD_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Merges the hazard and stall sources (memory wait, multi-cycle execute, branch/jump, load-use) into the single 3-bit hold_flag bus and the hold_time bus.
- Every pipeline register (if_id, id_ex, ex_mem) and the PC consume these buses.
- Also drives the jump redirect, the pipeline flush pulse and a stall-cycle performance counter.

Parameters:
- MULTI_CYCLES, 8, total hold cycles for one multi-cycle execute op; legal range 2..255.
- TIMEOUT_CYCLES, 255, memory-wait watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_req_i  in  1  MEM stage has a load/store in flight
- mem_ack_i  in  1  data bus completes the access this cycle
- multi_start_i  in  1  EX starts a multi-cycle op (mul/div)
- jump_flag_i  in  1  EX resolved a taken branch or jump
- jump_addr_i  in  32  redirect target
- load_use_i  in  1  ID detects a load-use hazard
- hold_flag_o  out  3  hold level: 000 none, 001 Hold_Pc, 010 Hold_If, 011 Hold_Id, 100 Hold_Ex
- hold_time_o  out  3  remaining hold cycles, saturated at 7
- jump_flag_o  out  1  PC redirect strobe
- jump_addr_o  out  32  PC redirect target
- flush_o  out  1  kill the IF/ID and ID/EX contents
- stall_cnt_o  out  32  count of cycles with hold_flag_o != 000
- bus_err_o  out  1  watchdog expiry pulse; tied to 0 without the optional feature

Behaviour:
- Reset values: state RUN, cnt 0, all outputs 0. Asserting rst in any state returns to RUN on the next evaluation.
- Outputs are combinational from state, cnt and the inputs. The same-cycle response is required, so the hold takes effect at the next clock edge.
- State RUN, priority high to low:
  1. mem_req_i && !mem_ack_i: hold_flag=100 and hold_time=111; go to MEMWAIT. If mem_req_i and mem_ack_i are both high, there is no hold.
  2. multi_start_i: hold_flag=011; load cnt=MULTI_CYCLES-1; go to MULTI.
  3. jump_flag_i: jump_flag_o=1, jump_addr_o=jump_addr_i, flush_o=1, hold_flag=000; stay in RUN.
  4. load_use_i: hold_flag=010 (PC and IF/ID frozen, bubble into ID/EX) for exactly one cycle.
  5. Otherwise: all 0.
- Lower-priority requests arriving in the same cycle are dropped. The stalled stage re-asserts them later, because its contents are frozen.
- State MEMWAIT:
  - hold_flag=100 and hold_time=111 until mem_ack_i.
  - In the ack cycle, hold_flag=000; next state is RUN.
  - All other inputs are ignored.
- State MULTI:
  - While cnt!=0: hold_flag=011, hold_time=min(cnt,7), decrement cnt.
  - When cnt==0: hold_flag=000; next state is RUN.
  - Total hold = MULTI_CYCLES cycles, counting the start cycle.
  - jump_flag_i, load_use_i and multi_start_i are ignored. mem_req_i cannot occur here (EX/MEM is held) and is ignored.
- jump_addr_o is 0 whenever jump_flag_o is 0.
- stall_cnt_o increments at each edge where hold_flag_o != 000. It wraps from FFFFFFFF to 0 and is not cleared except by rst.

Optional Feature:
- Macro: PIPE_HOLD_TIMEOUT_EN
- Enabled:
  - A wait counter clears on entry to MEMWAIT and increments every cycle in MEMWAIT.
  - When it reaches TIMEOUT_CYCLES without mem_ack_i, bus_err_o pulses high for 1 cycle, hold_flag=000 that cycle, and the next state is RUN.
  - An ack in the same cycle as the limit takes precedence: no error.
- Disabled: no wait counter is present, bus_err_o=0 constantly, and MEMWAIT waits indefinitely.

Test Plan:
- Reset, then hold all inputs at 0 for 10 cycles -> hold_flag 000, stall_cnt 0, all outputs 0.
- mem_req=1 for 4 cycles with ack in the 4th -> hold_flag 100 for 3 cycles, 000 in the ack cycle, stall_cnt=3. Separately, mem_req and ack together -> no hold.
- multi_start pulse with MULTI_CYCLES=8 -> hold_flag 011 for 8 cycles; hold_time sequence 000,111,110,101,100,011,010,001; stall_cnt=8. A jump_flag pulse inside this window is ignored.
- jump_flag=1, addr=0x00000100, with load_use=1 in the same cycle -> jump_flag_o=1, addr_o=0x100, flush=1, hold_flag 000. load_use alone -> hold_flag 010 for 1 cycle.
- Assert rst mid-MEMWAIT -> outputs go to 0 immediately; after release, state is RUN and stall_cnt=0.
- With PIPE_HOLD_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_req held with no ack -> bus_err pulses once, hold releases, controller returns to RUN.
